// File: rtl/semaforo_n_vias_pkg.sv
// Shared types and constants for the N-way traffic-light controller.
// The PISCA state is only reachable when SEMAFORO_PISCA_EN is defined.
package semaforo_n_vias_pkg;

   typedef enum logic [2:0] {
      VERDE    = 3'd0,
      AMARELO  = 3'd1,
      VERMELHO = 3'd2,
      PEDESTRE = 3'd3,
      PISCA    = 3'd4
   } estado_t;

   localparam logic [2:0] LUZ_VERDE    = 3'b100;
   localparam logic [2:0] LUZ_AMARELO  = 3'b010;
   localparam logic [2:0] LUZ_VERMELHO = 3'b001;
   localparam logic [2:0] LUZ_APAGADA  = 3'b000;

   localparam int unsigned CNT_W = 8;

   // Value loaded on phase entry so that the phase lasts exactly t cycles.
   function automatic logic [CNT_W-1:0] carga_fase(input int unsigned t);
      return CNT_W'(t - 1);
   endfunction

endpackage

// File: rtl/semaforo_n_vias_contador_fase.sv
// 8-bit loadable down-counter with enable and zero flag; saturates at zero.
module contador_fase
   import semaforo_n_vias_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/semaforo_n_vias.sv
// Round-robin N-way traffic-light controller with latched pedestrian walk phase.
// Define SEMAFORO_PISCA_EN to add the noturno input and the night flashing state.
module semaforo_n_vias
   import semaforo_n_vias_pkg::*;
#(
   parameter int unsigned N_WAYS     = 3,
   parameter int unsigned T_VERDE    = 4,
   parameter int unsigned T_AMARELO  = 2,
   parameter int unsigned T_VERMELHO = 1,
   parameter int unsigned T_PEDESTRE = 3,
   parameter int unsigned T_PISCA    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bt,
`ifdef SEMAFORO_PISCA_EN
   input  logic                noturno,
`endif
   output logic [3*N_WAYS-1:0] luzes,
   output logic                pedestre,
   output logic                ped_pendente,
   output logic [2:0]          via_ativa
);

   generate
      if ((N_WAYS < 2) || (N_WAYS > 8) ||
          (T_VERDE    < 1) || (T_VERDE    > 255) ||
          (T_AMARELO  < 1) || (T_AMARELO  > 255) ||
          (T_VERMELHO < 1) || (T_VERMELHO > 255) ||
          (T_PEDESTRE < 1) || (T_PEDESTRE > 255) ||
          (T_PISCA    < 1) || (T_PISCA    > 255)) begin : g_param_invalido
         $error("semaforo_n_vias: N_WAYS must be 2..8 and every duration 1..255");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CARGA_VERDE    = carga_fase(T_VERDE);
   localparam logic [CNT_W-1:0] CARGA_AMARELO  = carga_fase(T_AMARELO);
   localparam logic [CNT_W-1:0] CARGA_VERMELHO = carga_fase(T_VERMELHO);
   localparam logic [CNT_W-1:0] CARGA_PEDESTRE = carga_fase(T_PEDESTRE);
   localparam logic [2:0]       ULTIMA_VIA     = 3'(N_WAYS - 1);

   estado_t                estado_q, estado_d, estado_r;
   logic [2:0]             via_q, via_d, via_r, via_prox;
   logic                   pedido_q, pedido_d;
   logic                   cnt_load, cnt_zero;
   logic [CNT_W-1:0]       cnt_val;
   logic [3*N_WAYS-1:0]    luzes_q, luzes_d;
   logic                   pedestre_q, pedestre_d;

`ifdef SEMAFORO_PISCA_EN
   localparam logic [CNT_W-1:0] CARGA_PISCA = carga_fase(T_PISCA);
   logic                   pisca_load, pisca_zero;
   logic                   apagado_q, apagado_d, apagado_r;
   logic                   pos_pisca_q, pos_pisca_d;
`endif

   contador_fase #(
      .RST_VAL (CARGA_VERDE)
   ) u_cnt_fase (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (1'b1),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

`ifdef SEMAFORO_PISCA_EN
   contador_fase #(
      .RST_VAL ('0)
   ) u_cnt_pisca (
      .clk      (clk),
      .rst      (rst),
      .load     (pisca_load),
      .en       (estado_q == PISCA),
      .load_val (CARGA_PISCA),
      .zero     (pisca_zero)
   );
`endif

   assign via_prox = (via_q == ULTIMA_VIA) ? '0 : via_q + 3'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q    <= VERDE;
         via_q       <= '0;
         pedido_q    <= 1'b0;
`ifdef SEMAFORO_PISCA_EN
         apagado_q   <= 1'b0;
         pos_pisca_q <= 1'b0;
`endif
      end else begin
         estado_q    <= estado_d;
         via_q       <= via_d;
         pedido_q    <= pedido_d;
`ifdef SEMAFORO_PISCA_EN
         apagado_q   <= apagado_d;
         pos_pisca_q <= pos_pisca_d;
`endif
      end
      // Output decode already folds reset in via the *_r selects below.
      luzes_q    <= luzes_d;
      pedestre_q <= pedestre_d;
   end

   always_comb begin
      estado_d = estado_q;
      via_d    = via_q;
      cnt_load = 1'b0;
      cnt_val  = CARGA_VERDE;
`ifdef SEMAFORO_PISCA_EN
      pisca_load  = 1'b0;
      apagado_d   = apagado_q;
      pos_pisca_d = pos_pisca_q;
`endif
      case (estado_q)
         VERDE: begin
            if (cnt_zero) begin
               estado_d = AMARELO;
               cnt_load = 1'b1;
               cnt_val  = CARGA_AMARELO;
            end
         end
         AMARELO: begin
            if (cnt_zero) begin
               estado_d = VERMELHO;
               cnt_load = 1'b1;
               cnt_val  = CARGA_VERMELHO;
            end
         end
         VERMELHO: begin
            if (cnt_zero) begin
`ifdef SEMAFORO_PISCA_EN
               pos_pisca_d = 1'b0;
               if (noturno) begin
                  estado_d   = PISCA;
                  pisca_load = 1'b1;
                  apagado_d  = 1'b0;
               end else if (pedido_q && !pos_pisca_q) begin
`else
               if (pedido_q) begin
`endif
                  estado_d = PEDESTRE;
                  cnt_load = 1'b1;
                  cnt_val  = CARGA_PEDESTRE;
               end else begin
                  estado_d = VERDE;
                  via_d    = via_prox;
                  cnt_load = 1'b1;
                  cnt_val  = CARGA_VERDE;
               end
            end
         end
         PEDESTRE: begin
            if (cnt_zero) begin
               estado_d = VERDE;
               via_d    = via_prox;
               cnt_load = 1'b1;
               cnt_val  = CARGA_VERDE;
            end
         end
`ifdef SEMAFORO_PISCA_EN
         PISCA: begin
            if (pisca_zero) begin
               if (noturno) begin
                  pisca_load = 1'b1;
                  apagado_d  = !apagado_q;
               end else begin
                  estado_d    = VERMELHO;
                  cnt_load    = 1'b1;
                  cnt_val     = CARGA_VERMELHO;
                  pos_pisca_d = 1'b1;
               end
            end
         end
`endif
         default: begin
            estado_d = VERDE;
            via_d    = '0;
            cnt_load = 1'b1;
            cnt_val  = CARGA_VERDE;
         end
      endcase

      pedido_d = pedido_q;
      if ((estado_q != PEDESTRE) && bt) begin
         pedido_d = 1'b1;
      end
      if ((estado_d == PEDESTRE) && (estado_q != PEDESTRE)) begin
         pedido_d = 1'b0;
      end
   end

   always_comb begin
      estado_r = rst ? estado_d : VERDE;
      via_r    = rst ? via_d : '0;
`ifdef SEMAFORO_PISCA_EN
      apagado_r = rst ? apagado_d : 1'b0;
`endif
      pedestre_d = (estado_r == PEDESTRE);
      luzes_d    = '0;
      for (int unsigned i = 0; i < N_WAYS; i++) begin
         luzes_d[3*i +: 3] = LUZ_VERMELHO;
         case (estado_r)
            VERDE:   if (via_r == 3'(i)) luzes_d[3*i +: 3] = LUZ_VERDE;
            AMARELO: if (via_r == 3'(i)) luzes_d[3*i +: 3] = LUZ_AMARELO;
`ifdef SEMAFORO_PISCA_EN
            PISCA:   luzes_d[3*i +: 3] = apagado_r ? LUZ_APAGADA : LUZ_AMARELO;
`endif
            default: luzes_d[3*i +: 3] = LUZ_VERMELHO;
         endcase
      end
   end

   assign luzes        = luzes_q;
   assign pedestre     = pedestre_q;
   assign ped_pendente = pedido_q;
   assign via_ativa    = via_q;

endmodule

// File: tb/tb_semaforo_n_vias.sv
// Self-checking bench: default and corner-parameter instances against a phase-schedule model.
module tb_semaforo_n_vias;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bt  = 1'b0;
   logic [8:0] luzes_a;
   logic       ped_a, pend_a;
   logic [2:0] via_a;
   logic [5:0] luzes_b;
   logic       ped_b, pend_b;
   logic [2:0] via_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   semaforo_n_vias #(
      .N_WAYS(3), .T_VERDE(4), .T_AMARELO(2), .T_VERMELHO(1), .T_PEDESTRE(3), .T_PISCA(2)
   ) u_dut (
      .clk(clk), .rst(rst), .bt(bt),
`ifdef SEMAFORO_PISCA_EN
      .noturno(1'b0),
`endif
      .luzes(luzes_a), .pedestre(ped_a), .ped_pendente(pend_a), .via_ativa(via_a)
   );

   semaforo_n_vias #(
      .N_WAYS(2), .T_VERDE(1), .T_AMARELO(1), .T_VERMELHO(1), .T_PEDESTRE(3), .T_PISCA(2)
   ) u_cnr (
      .clk(clk), .rst(rst), .bt(bt),
`ifdef SEMAFORO_PISCA_EN
      .noturno(1'b0),
`endif
      .luzes(luzes_b), .pedestre(ped_b), .ped_pendente(pend_b), .via_ativa(via_b)
   );

   // Model: phase 0=green 1=yellow 2=all-red 3=walk, elapsed cycles in phase.
   int n_w   [2];
   int dur   [2][4];
   int m_fase[2];
   int m_dec [2];
   int m_via [2];
   bit m_ped [2];

   task automatic modelo(input int k, input logic r, input logic b);
      bit nped;
      if (!r) begin
         m_fase[k] = 0; m_dec[k] = 0; m_via[k] = 0; m_ped[k] = 0;
      end else begin
         nped = m_ped[k] | (b && (m_fase[k] != 3));
         if (m_dec[k] == dur[k][m_fase[k]] - 1) begin
            m_dec[k] = 0;
            case (m_fase[k])
               0: m_fase[k] = 1;
               1: m_fase[k] = 2;
               2: if (m_ped[k]) begin
                     m_fase[k] = 3; nped = 0;
                  end else begin
                     m_fase[k] = 0; m_via[k] = (m_via[k] + 1) % n_w[k];
                  end
               default: begin
                  m_fase[k] = 0; m_via[k] = (m_via[k] + 1) % n_w[k];
               end
            endcase
         end else begin
            m_dec[k]++;
         end
         m_ped[k] = nped;
      end
   endtask

   function automatic logic [31:0] esperado(input int k);
      logic [23:0] v;
      logic [2:0]  c;
      v = '0;
      for (int i = 0; i < n_w[k]; i++) begin
         c = 3'b001;
         if (m_via[k] == i && m_fase[k] == 0) c = 3'b100;
         if (m_via[k] == i && m_fase[k] == 1) c = 3'b010;
         v[3*i +: 3] = c;
      end
      return {v, m_fase[k] == 3, m_ped[k], 3'(m_via[k])};
   endfunction

   function automatic logic [31:0] atual(input int k);
      if (k == 0) return {15'b0, luzes_a, ped_a, pend_a, via_a};
      return {18'b0, luzes_b, ped_b, pend_b, via_b};
   endfunction

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nome, act, exp);
      end
   endtask

   task automatic ciclo(input logic r, input logic b);
      rst = r;
      bt  = b;
      @(posedge clk);
      modelo(0, r, b);
      modelo(1, r, b);
      #1;
      chk("modelo_3vias", atual(0), esperado(0));
      chk("modelo_2vias", atual(1), esperado(1));
   endtask

   typedef struct {
      logic       r;
      logic       b;
      logic [8:0] luz;
      logic       ped;
      logic       pend;
      logic [2:0] via;
   } vet_t;

   vet_t tab[23];

   initial begin
      n_w[0] = 3; dur[0][0] = 4; dur[0][1] = 2; dur[0][2] = 1; dur[0][3] = 3;
      n_w[1] = 2; dur[1][0] = 1; dur[1][1] = 1; dur[1][2] = 1; dur[1][3] = 3;
      for (int k = 0; k < 2; k++) begin
         m_fase[k] = 0; m_dec[k] = 0; m_via[k] = 0; m_ped[k] = 0;
      end

      tab[0]  = '{1'b0, 1'b0, 9'b001_001_100, 1'b0, 1'b0, 3'd0};
      tab[1]  = '{1'b1, 1'b1, 9'b001_001_100, 1'b0, 1'b1, 3'd0};
      tab[2]  = '{1'b1, 1'b0, 9'b001_001_100, 1'b0, 1'b1, 3'd0};
      tab[3]  = '{1'b1, 1'b0, 9'b001_001_100, 1'b0, 1'b1, 3'd0};
      tab[4]  = '{1'b1, 1'b0, 9'b001_001_010, 1'b0, 1'b1, 3'd0};
      tab[5]  = '{1'b1, 1'b0, 9'b001_001_010, 1'b0, 1'b1, 3'd0};
      tab[6]  = '{1'b1, 1'b0, 9'b001_001_001, 1'b0, 1'b1, 3'd0};
      tab[7]  = '{1'b1, 1'b1, 9'b001_001_001, 1'b1, 1'b0, 3'd0};
      tab[8]  = '{1'b1, 1'b1, 9'b001_001_001, 1'b1, 1'b0, 3'd0};
      tab[9]  = '{1'b1, 1'b0, 9'b001_001_001, 1'b1, 1'b0, 3'd0};
      tab[10] = '{1'b1, 1'b0, 9'b001_100_001, 1'b0, 1'b0, 3'd1};
      tab[11] = '{1'b1, 1'b0, 9'b001_100_001, 1'b0, 1'b0, 3'd1};
      tab[12] = '{1'b1, 1'b0, 9'b001_100_001, 1'b0, 1'b0, 3'd1};
      tab[13] = '{1'b1, 1'b0, 9'b001_100_001, 1'b0, 1'b0, 3'd1};
      tab[14] = '{1'b1, 1'b0, 9'b001_010_001, 1'b0, 1'b0, 3'd1};
      tab[15] = '{1'b1, 1'b0, 9'b001_010_001, 1'b0, 1'b0, 3'd1};
      tab[16] = '{1'b1, 1'b0, 9'b001_001_001, 1'b0, 1'b0, 3'd1};
      tab[17] = '{1'b1, 1'b0, 9'b100_001_001, 1'b0, 1'b0, 3'd2};
      tab[18] = '{1'b1, 1'b1, 9'b100_001_001, 1'b0, 1'b1, 3'd2};
      tab[19] = '{1'b1, 1'b0, 9'b100_001_001, 1'b0, 1'b1, 3'd2};
      tab[20] = '{1'b1, 1'b0, 9'b100_001_001, 1'b0, 1'b1, 3'd2};
      tab[21] = '{1'b1, 1'b0, 9'b010_001_001, 1'b0, 1'b1, 3'd2};
      tab[22] = '{1'b0, 1'b0, 9'b001_001_100, 1'b0, 1'b0, 3'd0};

      // Directed table: rotation, walk phase, bt across walk entry, reset mid-yellow.
      for (int i = 0; i < 23; i++) begin
         ciclo(tab[i].r, tab[i].b);
         chk($sformatf("tabela[%0d]", i), {23'b0, luzes_a, ped_a, pend_a, via_a},
             {23'b0, tab[i].luz, tab[i].ped, tab[i].pend, tab[i].via});
      end

      // Way0 returns to green 21 cycles after reset; corner instance wraps 1->0.
      for (int c = 1; c <= 21; c++) begin
         ciclo(1'b1, 1'b0);
         if (c == 3) chk("cnr_via1_verde", {26'b0, luzes_b, via_b}, {26'b0, 6'b100_001, 3'd1});
         if (c == 6) chk("cnr_wrap_via0", {26'b0, luzes_b, via_b}, {26'b0, 6'b001_100, 3'd0});
         if (c == 20) chk("todos_vermelho", {20'b0, luzes_a, via_a}, {20'b0, 9'b001_001_001, 3'd2});
      end
      chk("via0_apos_21", {20'b0, luzes_a, via_a}, {20'b0, 9'b001_001_100, 3'd0});

      // bt pulse only inside walk phase must not request a second walk.
      ciclo(1'b0, 1'b0);
      ciclo(1'b1, 1'b1);
      for (int c = 2; c <= 17; c++) begin
         ciclo(1'b1, c == 8);
         if (c == 9)  chk("bt_em_pedestre_ignorado", {30'b0, ped_a, pend_a}, {30'b0, 1'b1, 1'b0});
         if (c == 17) chk("sem_segundo_pedestre", {30'b0, ped_a, pend_a}, {30'b0, 1'b0, 1'b0});
      end

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         ciclo($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
